// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed 7-seg scanner: blank/show per digit, frame-aligned
// double-buffered display value, optional leading-zero suppression.
module seg_scan_mux #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        lz_blank,
    output logic [3:0]  digit_bcd,
    output logic [3:0]  an,
    output logic [1:0]  digit_sel,
    output logic        pending,
    output logic        frame_tick
);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t      state, state_nxt;
    logic [19:0] cnt, cnt_nxt;
    logic [1:0]  sel_nxt;
    logic [15:0] pend_reg, disp_reg, disp_nxt;
    logic        boundary;
    logic        supp;
    logic [3:0]  an_nxt, bcd_nxt;

    // Outputs are computed from next-state values so the registered outputs
    // line up with the state registers on the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 20'd1;
        sel_nxt   = digit_sel;
        boundary  = 1'b0;
        case (state)
            BLANK: if (cnt == 20'(BLANK_CYCLES - 1)) begin
                state_nxt = SHOW;
                cnt_nxt   = '0;
            end
            SHOW: if (cnt == 20'(CLK_DIV - 1)) begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
                sel_nxt   = digit_sel + 2'd1;
                boundary  = (digit_sel == 2'd3);
            end
            default: state_nxt = BLANK;
        endcase

        disp_nxt = (boundary && pending) ? pend_reg : disp_reg;

        case (sel_nxt)
            2'd1:    supp = lz_blank && (disp_nxt[15:4]  == 12'd0);
            2'd2:    supp = lz_blank && (disp_nxt[15:8]  == 8'd0);
            2'd3:    supp = lz_blank && (disp_nxt[15:12] == 4'd0);
            default: supp = 1'b0;
        endcase

        an_nxt = 4'b1111;
        if (state_nxt == SHOW && !supp)
            an_nxt[sel_nxt] = 1'b0;
        bcd_nxt = supp ? 4'hF : disp_nxt[{sel_nxt, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK;
            cnt        <= '0;
            digit_sel  <= '0;
            pend_reg   <= '0;
            disp_reg   <= '0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            an         <= 4'b1111;
            digit_bcd  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            digit_sel  <= sel_nxt;
            disp_reg   <= disp_nxt;
            // a load on the boundary edge re-arms pending for the new value
            if (load)
                pend_reg <= value_in;
            pending    <= load | (pending & ~boundary);
            frame_tick <= boundary;
            an         <= an_nxt;
            digit_bcd  <= bcd_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with CLK_DIV=4, BLANK_CYCLES=1 (20-cycle frame).
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic        lz_blank;
    logic [3:0]  digit_bcd;
    logic [3:0]  an;
    logic [1:0]  digit_sel;
    logic        pending;
    logic        frame_tick;

    int nvec = 0;
    int nerr = 0;
    int n;

    seg_scan_mux #(.CLK_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .load(load), .lz_blank(lz_blank),
        .digit_bcd(digit_bcd), .an(an), .digit_sel(digit_sel),
        .pending(pending), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns at the negedge of the frame_tick cycle; n = negedges waited.
    task automatic wait_ft(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!frame_tick && cnt < 200);
        if (!frame_tick) chk("ft_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v);
        @(posedge clk); #1;
        load = 1'b1; value_in = v;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Called at the negedge of the tick cycle; ends at the negedge of cycle 19.
    task automatic check_frame(input logic [15:0] v, input logic lz);
        int d, ph;
        logic s;
        logic [3:0] ea, eb;
        logic [15:0] sh;
        for (int c = 0; c < 20; c++) begin
            d  = c / 5;
            ph = c % 5;
            sh = v >> (4 * d);
            s  = lz && (d != 0) && (sh == 16'd0);
            ea = (ph == 0 || s) ? 4'b1111 : ~(4'b0001 << d);
            eb = s ? 4'hF : sh[3:0];
            chk($sformatf("frame %h c%0d {ft,an,bcd,sel}", v, c),
                {21'd0, frame_tick, an, digit_bcd, digit_sel},
                {21'd0, (c == 0), ea, eb, 2'(d)});
            if (c < 19) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b1; value_in = 16'hABCD; lz_blank = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_bcd", {28'd0, digit_bcd}, 32'h0);
        chk("rst_sel", {30'd0, digit_sel}, 32'h0);
        chk("rst_pending_vs_load", {31'd0, pending}, 32'h0);
        chk("rst_ft", {31'd0, frame_tick}, 32'h0);
        load = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Scenario 1
        load = 1'b1; value_in = 16'h1234;
        @(posedge clk); #1;
        load = 1'b0;
        @(negedge clk);
        chk("s1_pending_set", {31'd0, pending}, 32'h1);
        wait_ft(n);
        chk("s1_first_tick", n, 32'd19);
        chk("s1_pending_clr", {31'd0, pending}, 32'h0);
        check_frame(16'h1234, 1'b0);

        // Scenario 2
        lz_blank = 1'b1;
        do_load(16'h0070);
        wait_ft(n);
        check_frame(16'h0070, 1'b1);
        do_load(16'h0000);
        wait_ft(n);
        check_frame(16'h0000, 1'b1);

        // Scenario 3
        lz_blank = 1'b0;
        do_load(16'h1111);
        do_load(16'h2222);
        wait_ft(n);
        chk("s3_pending_clr", {31'd0, pending}, 32'h0);
        check_frame(16'h2222, 1'b0);

        // Scenario 4: 5678 loaded on the boundary edge while 1111 is pending
        do_load(16'h1111);
        repeat (19) @(negedge clk);
        chk("s4_pending_pre", {31'd0, pending}, 32'h1);
        load = 1'b1; value_in = 16'h5678;
        @(posedge clk); #1;
        load = 1'b0;
        wait_ft(n);
        chk("s4_tick_align", n, 32'd1);
        chk("s4_pending_kept", {31'd0, pending}, 32'h1);
        check_frame(16'h1111, 1'b0);
        wait_ft(n);
        chk("s4_pending_clr", {31'd0, pending}, 32'h0);
        check_frame(16'h5678, 1'b0);

        // Scenario 5: reset during SHOW of digit 2
        repeat (12) @(negedge clk);
        chk("s5_in_show2", {28'd0, an}, 32'hB);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("s5_an", {28'd0, an}, 32'hF);
        chk("s5_sel", {30'd0, digit_sel}, 32'h0);
        chk("s5_bcd", {28'd0, digit_bcd}, 32'h0);
        chk("s5_ft", {31'd0, frame_tick}, 32'h0);
        wait_ft(n);
        chk("s5_first_tick", n, 32'd20);
        check_frame(16'h0000, 1'b0);

        // Scenario 6: free-run with hex nibbles and one suppressed digit
        lz_blank = 1'b1;
        do_load(16'h0A0B);
        wait_ft(n);
        for (int f = 0; f < 10; f++) begin
            if (f > 0) begin
                wait_ft(n);
                chk($sformatf("s6_period f%0d", f), n, 32'd1);
            end
            check_frame(16'h0A0B, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50000: clock cycles each digit is driven (SHOW phase), legal range 2..2^20.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 4: anti-ghosting cycles with all anodes off before each digit, legal range 1..255.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port value_in, input, 16 bits: four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 Port load, input, 1 bit: single-cycle strobe; captures value_in.
REQ-007 Port lz_blank, input, 1 bit: 1 enables leading-zero suppression.
REQ-008 Port digit_bcd, output, 4 bits: nibble for the downstream segment decoder.
REQ-009 Port an, output, 4 bits: active-low anode enables; an[i] drives digit i.
REQ-010 Port digit_sel, output, 2 bits: index of the digit currently scanned.
REQ-011 Port pending, output, 1 bit: a loaded value is waiting for the next frame boundary.
REQ-012 Port frame_tick, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-013 Registers: pend_reg (16 bits), disp_reg (16 bits), pending flag, phase counter, digit index, and a two-state FSM {BLANK, SHOW}.
REQ-014 load=1 SHALL write value_in to pend_reg and set pending on the next edge; a later load before the boundary overwrites pend_reg (last load wins).
REQ-015 BLANK SHALL last exactly BLANK_CYCLES cycles, with an=4'b1111; it then moves to SHOW with the counter cleared.
REQ-016 SHOW SHALL last exactly CLK_DIV cycles, driving an[digit_sel]=0 and the other anodes 1; it then moves to BLANK and digit_sel increments modulo 4 (3 wraps to 0).
REQ-017 Frame length SHALL be 4*(BLANK_CYCLES+CLK_DIV) cycles with no gap or extra cycle.
REQ-018 Frame boundary is the edge on which SHOW of digit 3 ends; frame_tick SHALL be 1 for the cycle after that edge (first BLANK cycle of digit 0).
REQ-019 At the boundary, if pending=1, disp_reg SHALL take the pre-edge pend_reg and pending SHALL clear; if pending=0, disp_reg is unchanged.
REQ-020 load coincident with the boundary edge: disp_reg takes the old pend_reg, pend_reg takes value_in, pending stays 1; the new value displays one frame later.
REQ-021 digit_bcd SHALL equal disp_reg nibble [4*digit_sel+3 : 4*digit_sel] in both phases; it is registered and aligned with an.
REQ-022 Leading-zero suppression applies when lz_blank=1. Digit i (i>=1) SHALL be suppressed when nibble i and every higher nibble are 0. A suppressed digit keeps an=4'b1111 during its SHOW phase and digit_bcd=4'hF. Digit 0 is never suppressed.
REQ-023 Nibbles 10..15 SHALL pass through unmodified to digit_bcd; the downstream decoder blanks them.
REQ-024 lz_blank SHALL be sampled every cycle; no latching.
REQ-025 Every output SHALL be driven from a register; there are no combinational paths from inputs to outputs.

Reset
REQ-026 While rst=1: an=4'b1111, digit_bcd=0, digit_sel=0, pending=0, frame_tick=0, pend_reg=0, disp_reg=0, FSM=BLANK, counter=0.
REQ-027 rst SHALL override load in the same cycle.
REQ-028 Reset mid-frame SHALL abort the scan. The first cycle after rst is deasserted starts BLANK of digit 0 with no frame_tick.
REQ-029 Outputs are undefined before the first reset; the bench SHALL apply at least 1 cycle of rst.

Verification (CLK_DIV=4, BLANK_CYCLES=1, frame=20 cycles)
REQ-030 Scenario 1: reset, then load 16'h1234 -> pending=1; after the next frame_tick the display shows an=1110/digit_bcd=4 for 4 cycles, then an=1111 for 1 cycle, then an=1101/3, 1011/2, 0111/1; pending=0.
REQ-031 Scenario 2: lz_blank=1, load 16'h0070 -> digits 0 and 1 are shown (0, 7); digits 2 and 3 have an=1111 and digit_bcd=F. Load 16'h0000 -> only digit 0 is shown (0).
REQ-032 Scenario 3: load 16'h1111 then 16'h2222 within one frame -> only 2222 is ever displayed.
REQ-033 Scenario 4: load 16'h5678 on the boundary edge while 16'h1111 is pending -> the next frame shows 1111 and the following frame shows 5678.
REQ-034 Scenario 5: rst pulsed during SHOW of digit 2 -> next cycle an=1111, disp_reg=0, digit_sel=0; frame_tick first occurs 20 cycles after rst is released.
REQ-035 Scenario 6: free-run 10 frames -> frame_tick period is exactly 20 cycles and no cycle has two anodes low at once.
